// File: rtl/pwm_multicanal.sv
// Multi-channel PWM with a shared edge/center-aligned counter.
// Duty and mode are double-buffered and switch only at a period boundary.
module pwm_multicanal #(
  parameter int CH     = 4,
  parameter int TP     = 8,
  parameter int N_BIT  = 14,
  parameter int SD     = 40,
  parameter int PERIOD = 10000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [CH*TP-1:0] duty_i,
  output logic [CH-1:0]    pwm,
  output logic             period_end,
  output logic [N_BIT-1:0] cnt_o
);

  localparam int W = TP + N_BIT;
  localparam logic [N_BIT-1:0] TOP = N_BIT'(PERIOD - 1);
  localparam logic [N_BIT-1:0] ONE = N_BIT'(1);
  localparam logic [W-1:0] PER_W = W'(PERIOD);
  localparam logic [W-1:0] SD_W = W'(SD);

  logic [N_BIT-1:0] cnt;
  logic [N_BIT-1:0] cnt_nx;
  logic             dir_dn;
  logic             dir_nx;
  logic             bnd;
  logic [CH*TP-1:0] pend_duty;
  logic [CH*TP-1:0] act_duty;
  logic             pend_mode;
  logic             act_mode;
  logic [CH-1:0]    cmp;
  logic [W-1:0]     prod [CH];
  logic [W-1:0]     thr  [CH];

  always_comb begin
    cnt_nx = cnt;
    dir_nx = dir_dn;
    bnd    = 1'b0;
    unique case (1'b1)
      !en: begin
        cnt_nx = '0;
        dir_nx = 1'b0;
      end
      en && !act_mode: begin
        if (cnt == TOP) begin
          cnt_nx = '0;
          bnd    = 1'b1;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      en && act_mode && !dir_dn: begin
        if (cnt == TOP) begin
          cnt_nx = cnt - ONE;
          dir_nx = 1'b1;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      en && act_mode && dir_dn: begin
        cnt_nx = cnt - ONE;
        if (cnt == ONE) begin
          bnd    = 1'b1;
          dir_nx = 1'b0;
        end
      end
    endcase
  end

  // Full-width product so large duties clamp instead of wrapping.
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      prod[k] = W'(act_duty[k*TP +: TP]) * SD_W;
      thr[k]  = (prod[k] > PER_W) ? PER_W : prod[k];
      cmp[k]  = W'(cnt) < thr[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      dir_dn     <= 1'b0;
      pend_duty  <= '0;
      act_duty   <= '0;
      pend_mode  <= 1'b0;
      act_mode   <= 1'b0;
      pwm        <= '0;
      period_end <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      dir_dn     <= dir_nx;
      period_end <= bnd;
      pwm        <= en ? cmp : '0;
      if (load) begin
        pend_duty <= duty_i;
        pend_mode <= mode;
      end
      if (!en || bnd) begin
        act_duty <= pend_duty;
        act_mode <= pend_mode;
      end
    end
  end

  assign cnt_o = cnt;

endmodule
